// File: rtl/tlb_cfg_pkg.sv
// Shared types and constants for the C2H TLB configuration register file:
// AXI-Lite request/response structs, the TLB entry record, the address
// decode record, the FSM state encodings and word-level helper functions.
package tlb_cfg_pkg;

    localparam int unsigned LiteAddrWidth = 32;
    localparam int unsigned LiteDataWidth = 32;

    // Word offsets inside one 16-byte entry
    localparam logic [1:0] WordFirst = 2'd0;
    localparam logic [1:0] WordLast  = 2'd1;
    localparam logic [1:0] WordBase  = 2'd2;
    localparam logic [1:0] WordFlags = 2'd3;

    localparam logic [11:0] LockOffset = 12'hFFC;
    localparam logic [31:0] WindowSize = 32'h1000;

    // AXI response codes
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    // AXI-Lite request; protection bits are not carried because this slave
    // treats every access identically.
    typedef struct packed {
        logic [LiteAddrWidth-1:0]   aw_addr;
        logic                       aw_valid;
        logic [LiteDataWidth-1:0]   w_data;
        logic [LiteDataWidth/8-1:0] w_strb;
        logic                       w_valid;
        logic                       b_ready;
        logic [LiteAddrWidth-1:0]   ar_addr;
        logic                       ar_valid;
        logic                       r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic                     aw_ready;
        logic                     w_ready;
        logic [1:0]               b_resp;
        logic                     b_valid;
        logic                     ar_ready;
        logic [LiteDataWidth-1:0] r_data;
        logic [1:0]               r_resp;
        logic                     r_valid;
    } axi_lite_resp_t;

    typedef struct packed {
        logic [31:0] first_page;
        logic [31:0] last_page;
        logic [31:0] base_page;
        logic        valid;
        logic        read_only;
    } tlb_entry_t;

    typedef struct packed {
        logic [7:0] index;
        logic [1:0] word;
        logic       decerr;
        logic       is_lock;
    } addr_dec_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_W,
        W_WAIT_AW,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    // Merge the strobed bytes of new_word over old_word
    function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

    // Bus view of one word of an entry; unused flag bits read as zero
    function automatic logic [31:0] entry_word(input tlb_entry_t e,
                                               input logic [1:0] word);
        case (word)
            WordFirst: return e.first_page;
            WordLast:  return e.last_page;
            WordBase:  return e.base_page;
            default:   return {30'b0, e.read_only, e.valid};
        endcase
    endfunction

    // Replace one word of an entry; upper flag bits are dropped
    function automatic tlb_entry_t set_entry_word(input tlb_entry_t  e,
                                                  input logic [1:0]  word,
                                                  input logic [31:0] value);
        tlb_entry_t n;
        n = e;
        case (word)
            WordFirst: n.first_page = value;
            WordLast:  n.last_page  = value;
            WordBase:  n.base_page  = value;
            default: begin
                n.valid     = value[0];
                n.read_only = value[1];
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/axi_lite_tlb_cfg_regs.sv
// AXI-Lite slave holding the C2H TLB entry table. Independent write and read
// handshake FSMs, address decode into 16-byte entries, and a registered flat
// entry table output for the TLB.
// Optional feature: define TLB_CFG_LOCK_EN to add the sticky lock register at
// offset 0xFFC that blocks entry writes (SLVERR) once set.
module axi_lite_tlb_cfg_regs
    import tlb_cfg_pkg::*;
#(
    parameter int unsigned              NumEntries   = 8,
    parameter int unsigned              AxiAddrWidth = 32,
    parameter int unsigned              AxiDataWidth = 32,
    parameter logic [AxiAddrWidth-1:0]  BaseAddr     = 32'h1040_0000,
    parameter type                      req_lite_t   = axi_lite_req_t,
    parameter type                      resp_lite_t  = axi_lite_resp_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  req_lite_t                    axi_req_i,
    output resp_lite_t                   axi_resp_o,
    output tlb_entry_t [NumEntries-1:0]  entries_o
);

    if (AxiDataWidth != 32) begin : g_bad_data_width
        $fatal(1, "axi_lite_tlb_cfg_regs: only 32-bit AXI-Lite data is supported");
    end
    if (NumEntries < 1 || NumEntries > 255) begin : g_bad_num_entries
        $fatal(1, "axi_lite_tlb_cfg_regs: NumEntries must be in 1..255");
    end

    // Write channel
    w_state_e                  w_state_q, w_state_d;
    logic [AxiAddrWidth-1:0]   aw_addr_q, wr_addr;
    logic [AxiDataWidth-1:0]   w_data_q, wr_data;
    logic [AxiDataWidth/8-1:0] w_strb_q, wr_strb;
    logic                      aw_ready, w_ready;
    logic                      latch_aw, latch_w, wr_commit;
    addr_dec_t                 wr_dec;
    logic [1:0]                wr_resp, b_resp_q;
    logic                      wr_entry_en;

    // Read channel
    r_state_e                  r_state_q, r_state_d;
    logic                      ar_ready, rd_capture;
    addr_dec_t                 rd_dec;
    logic [AxiDataWidth-1:0]   rd_word, r_data_q;
    logic [1:0]                rd_resp, r_resp_q;

    // Storage
    tlb_entry_t [NumEntries-1:0] entry_q;
    logic                        lock_q;
`ifdef TLB_CFG_LOCK_EN
    logic                        wr_lock_set;
`endif

    // Map a bus address onto entry index / word, flagging unmapped offsets
    function automatic addr_dec_t decode(input logic [AxiAddrWidth-1:0] addr);
        addr_dec_t               d;
        logic [AxiAddrWidth-1:0] off;
        off       = addr - BaseAddr;
        d.index   = off[11:4];
        d.word    = off[3:2];
        d.decerr  = 1'b1;
        d.is_lock = 1'b0;
        // Addresses below BaseAddr wrap to a huge offset and fail this test
        if (off < WindowSize) begin
`ifdef TLB_CFG_LOCK_EN
            if (off[11:0] == LockOffset) begin
                d.is_lock = 1'b1;
                d.decerr  = 1'b0;
            end else
`endif
            if (32'(d.index) < NumEntries) d.decerr = 1'b0;
        end
        return d;
    endfunction

    // Write FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments for every flop so all state updates
        // see pre-edge values regardless of statement order.
        if (!rst_ni) w_state_q <= W_IDLE;
        else         w_state_q <= w_state_d;
    end

    // Write FSM next state, ready outputs and selection of the committing beat
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned and no latch is inferred.
        w_state_d = w_state_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        latch_aw  = 1'b0;
        latch_w   = 1'b0;
        wr_commit = 1'b0;
        wr_addr   = aw_addr_q;
        wr_data   = w_data_q;
        wr_strb   = w_strb_q;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                w_ready  = 1'b1;
                if (axi_req_i.aw_valid && axi_req_i.w_valid) begin
                    wr_addr   = axi_req_i.aw_addr;
                    wr_data   = axi_req_i.w_data;
                    wr_strb   = axi_req_i.w_strb;
                    wr_commit = 1'b1;
                    w_state_d = W_RESP;
                end else if (axi_req_i.aw_valid) begin
                    latch_aw  = 1'b1;
                    w_state_d = W_WAIT_W;
                end else if (axi_req_i.w_valid) begin
                    latch_w   = 1'b1;
                    w_state_d = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                w_ready = 1'b1;
                if (axi_req_i.w_valid) begin
                    wr_data   = axi_req_i.w_data;
                    wr_strb   = axi_req_i.w_strb;
                    wr_commit = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_WAIT_AW: begin
                aw_ready = 1'b1;
                if (axi_req_i.aw_valid) begin
                    wr_addr   = axi_req_i.aw_addr;
                    wr_commit = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            default: begin
                if (axi_req_i.b_ready) w_state_d = W_IDLE;
            end
        endcase
    end

    // Write decode: response code and which storage the committing beat hits
    always_comb begin
        wr_dec      = decode(wr_addr);
        wr_resp     = RespOkay;
        wr_entry_en = 1'b0;
`ifdef TLB_CFG_LOCK_EN
        wr_lock_set = 1'b0;
`endif
        if (wr_dec.decerr) begin
            wr_resp = RespDecerr;
        end else if (wr_dec.is_lock) begin
`ifdef TLB_CFG_LOCK_EN
            wr_lock_set = wr_commit && wr_strb[0] && wr_data[0];
`endif
        end else if (lock_q) begin
            wr_resp = RespSlverr;
        end else begin
            wr_entry_en = wr_commit;
        end
    end

    // Capture an early AW or W beat and the response of the committed write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= RespOkay;
        end else begin
            if (latch_aw)  aw_addr_q <= axi_req_i.aw_addr;
            if (latch_w) begin
                w_data_q <= axi_req_i.w_data;
                w_strb_q <= axi_req_i.w_strb;
            end
            if (wr_commit) b_resp_q <= wr_resp;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state_q <= R_IDLE;
        else         r_state_q <= r_state_d;
    end

    // Read FSM next state and ready output
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready   = 1'b0;
        rd_capture = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (axi_req_i.ar_valid) begin
                    rd_capture = 1'b1;
                    r_state_d  = R_RESP;
                end
            end
            default: begin
                if (axi_req_i.r_ready) r_state_d = R_IDLE;
            end
        endcase
    end

    // Read decode and data mux over the current (pre-write) table
    always_comb begin
        rd_dec  = decode(axi_req_i.ar_addr);
        rd_word = '0;
        rd_resp = RespOkay;
        if (rd_dec.decerr) begin
            rd_resp = RespDecerr;
        end else if (rd_dec.is_lock) begin
            rd_word = {31'b0, lock_q};
        end else begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                if (rd_dec.index == 8'(i)) rd_word = entry_word(entry_q[i], rd_dec.word);
            end
        end
    end

    // Hold read data and response stable until the R handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data_q <= '0;
            r_resp_q <= RespOkay;
        end else if (rd_capture) begin
            r_data_q <= rd_word;
            r_resp_q <= rd_resp;
        end
    end

    // Entry table update with byte strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the table is plain flops, not a RAM, and is reset so every
        // entry comes up invalid before the TLB looks at it.
        if (!rst_ni) begin
            entry_q <= '0;
        end else if (wr_entry_en) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                if (wr_dec.index == 8'(i)) begin
                    entry_q[i] <= set_entry_word(entry_q[i], wr_dec.word,
                                      apply_strb(entry_word(entry_q[i], wr_dec.word),
                                                 wr_data, wr_strb));
                end
            end
        end
    end

`ifdef TLB_CFG_LOCK_EN
    // Sticky lock: set by writing 1 to bit 0, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          lock_q <= 1'b0;
        else if (wr_lock_set) lock_q <= 1'b1;
    end
`else
    assign lock_q = 1'b0;
`endif

    // Drive the response struct and table output
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.b_valid  = (w_state_q == W_RESP);
        axi_resp_o.b_resp   = b_resp_q;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.r_valid  = (r_state_q == R_RESP);
        axi_resp_o.r_data   = r_data_q;
        axi_resp_o.r_resp   = r_resp_q;
    end

    assign entries_o = entry_q;

endmodule

// File: tb/tb_axi_lite_tlb_cfg_regs.sv
// Self-checking bench for axi_lite_tlb_cfg_regs. Directed scenarios plus a
// randomized sweep checked against an array-based model of the register map.
// Lock scenarios are compiled in when TLB_CFG_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_axi_lite_tlb_cfg_regs;
    import tlb_cfg_pkg::*;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h1040_0000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    axi_lite_req_t         req;
    axi_lite_resp_t        rsp;
    tlb_entry_t [N-1:0]    entries;

    int n_checks = 0;
    int n_errors = 0;
    int b_count  = 0;

    logic [31:0] model_mem [N][4];
    bit          model_lock;

    always #5 clk = ~clk;

    axi_lite_tlb_cfg_regs #(.NumEntries(N), .BaseAddr(BASE)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .axi_req_i  (req),
        .axi_resp_o (rsp),
        .entries_o  (entries)
    );

    always @(posedge clk) if (rsp.b_valid && req.b_ready) b_count <= b_count + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int i = 0; i < N; i++)
            for (int w = 0; w < 4; w++) model_mem[i][w] = 32'h0;
        model_lock = 1'b0;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] off = addr - BASE;
        int idx = int'(off >> 4);
        int wd  = int'((off >> 2) & 32'h3);
        if (off >= 32'h1000) return RespDecerr;
`ifdef TLB_CFG_LOCK_EN
        if ((off & 32'hFFC) == 32'hFFC) begin
            if (strb[0] && data[0]) model_lock = 1'b1;
            return RespOkay;
        end
`endif
        if (idx >= N) return RespDecerr;
        if (model_lock) return RespSlverr;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[idx][wd] = (model_mem[idx][wd] & ~(32'hFF << (8*b)))
                                             | (data & (32'hFF << (8*b)));
        if (wd == 3) model_mem[idx][wd] = model_mem[idx][wd] & 32'h3;
        return RespOkay;
    endfunction

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        logic [31:0] off = addr - BASE;
        int idx = int'(off >> 4);
        int wd  = int'((off >> 2) & 32'h3);
        data = 32'h0;
        resp = RespDecerr;
        if (off >= 32'h1000) return;
`ifdef TLB_CFG_LOCK_EN
        if ((off & 32'hFFC) == 32'hFFC) begin
            data = {31'b0, model_lock};
            resp = RespOkay;
            return;
        end
`endif
        if (idx >= N) return;
        data = model_mem[idx][wd];
        resp = RespOkay;
    endfunction

    // Index of the first entry differing from the model, or -1
    function automatic int table_mismatch();
        for (int i = 0; i < N; i++) begin
            if (entries[i].first_page !== model_mem[i][0] ||
                entries[i].last_page  !== model_mem[i][1] ||
                entries[i].base_page  !== model_mem[i][2] ||
                {30'b0, entries[i].read_only, entries[i].valid} !== model_mem[i][3])
                return i;
        end
        return -1;
    endfunction

    // ---------------- bus drivers (called at a negedge, return at a negedge) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay,
                            output logic [1:0] resp, output bit timed_out);
        int t = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        timed_out   = 0;
        req.aw_addr = addr;
        req.w_data  = data;
        req.w_strb  = strb;
        req.b_ready = 1'b1;
        while (!(aw_done && w_done)) begin
            req.aw_valid = !aw_done && (t >= aw_delay);
            req.w_valid  = !w_done && (t >= w_delay);
            aw_hs = req.aw_valid && rsp.aw_ready;
            w_hs  = req.w_valid && rsp.w_ready;
            @(negedge clk);
            aw_done |= aw_hs;
            w_done  |= w_hs;
            t++;
            if (t > 50) begin timed_out = 1; break; end
        end
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        t = 0;
        while (!rsp.b_valid && t < 20) begin @(negedge clk); t++; end
        if (!rsp.b_valid) timed_out = 1;
        resp = rsp.b_resp;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output bit latency_ok, output bit timed_out);
        int t = 0;
        timed_out    = 0;
        req.r_ready  = 1'b1;
        req.ar_addr  = addr;
        req.ar_valid = 1'b1;
        while (!rsp.ar_ready && t < 20) begin @(negedge clk); t++; end
        if (!rsp.ar_ready) timed_out = 1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        latency_ok   = rsp.r_valid;
        data         = rsp.r_data;
        resp         = rsp.r_resp;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req   = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid} !== 5'b11100) begin
            n_errors++;
            $display("FAIL reset_handshake: got %b expected 11100",
                     {rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid});
        end
        n_checks++;
        if ({rsp.b_resp, rsp.r_resp, rsp.r_data} !== 36'h0) begin
            n_errors++;
            $display("FAIL reset_resp: b_resp=%b r_resp=%b r_data=%h expected all 0",
                     rsp.b_resp, rsp.r_resp, rsp.r_data);
        end
        n_checks++;
        if (entries !== '0) begin
            n_errors++;
            $display("FAIL reset_entries: got nonzero table, expected all 0");
        end
    endtask

    task automatic test_basic_write();
        logic [1:0] exp_resp;
        exp_resp     = model_write(BASE + 32'h10, 32'h0000_1234, 4'hF);
        req.aw_addr  = BASE + 32'h10;
        req.w_data   = 32'h0000_1234;
        req.w_strb   = 4'hF;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        n_checks++;
        if (rsp.b_valid !== 1'b1 || rsp.b_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL basic_write_b: b_valid=%b b_resp=%b expected 1/%b", rsp.b_valid, rsp.b_resp, exp_resp);
        end
        n_checks++;
        if (entries[1].first_page !== 32'h0000_1234) begin
            n_errors++;
            $display("FAIL basic_write_entry: got %h expected 00001234", entries[1].first_page);
        end
        @(negedge clk);
        n_checks++;
        if (rsp.b_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_write_b_done: b_valid=%b expected 0", rsp.b_valid);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] exp_resp;
        int         b_snap;
        b_snap      = b_count;
        exp_resp    = model_write(BASE + 32'h24, 32'hAABB_CCDD, 4'b0010);
        req.aw_addr = BASE + 32'h24;
        req.w_data  = 32'hAABB_CCDD;
        req.w_strb  = 4'b0010;
        req.b_ready = 1'b1;
        req.w_valid = 1'b1;
        @(negedge clk);
        req.w_valid = 1'b0;
        req.w_data  = 32'h0;
        n_checks++;
        if (rsp.w_ready !== 1'b0 || rsp.aw_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL w_first_ready: w_ready=%b aw_ready=%b expected 0/1", rsp.w_ready, rsp.aw_ready);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (rsp.b_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL w_first_early_b: b_valid=%b expected 0", rsp.b_valid);
        end
        req.aw_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        n_checks++;
        if (rsp.b_valid !== 1'b1 || rsp.b_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL w_first_b: b_valid=%b b_resp=%b expected 1/%b", rsp.b_valid, rsp.b_resp, exp_resp);
        end
        n_checks++;
        if (entries[2].last_page !== 32'h0000_CC00) begin
            n_errors++;
            $display("FAIL w_first_value: got %h expected 0000cc00", entries[2].last_page);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (b_count - b_snap !== 1) begin
            n_errors++;
            $display("FAIL w_first_b_count: got %0d responses expected 1", b_count - b_snap);
        end
    endtask

    task automatic test_decode_errors();
        logic [31:0] addrs [4];
        logic [31:0] got_data, exp_data;
        logic [1:0]  got_resp, exp_resp;
        bit          lat, to;
        int          bad;
        addrs[0] = BASE + 32'h90;
        addrs[1] = BASE + 32'h1000;
        addrs[2] = BASE - 32'h4;
        addrs[3] = BASE + 32'hFFC;
        for (int k = 0; k < 4; k++) begin
            model_read(addrs[k], exp_data, exp_resp);
            do_read(addrs[k], got_data, got_resp, lat, to);
            n_checks++;
            if (to || !lat || got_resp !== exp_resp || got_data !== exp_data) begin
                n_errors++;
                $display("FAIL decode_read[%0d]: resp=%b data=%h lat=%b to=%b expected %b/%h",
                         k, got_resp, got_data, lat, to, exp_resp, exp_data);
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_resp = model_write(addrs[k], 32'hFFFF_FFFF, 4'hF);
            do_write(addrs[k], 32'hFFFF_FFFF, 4'hF, 0, 0, got_resp, to);
            bad = table_mismatch();
            n_checks++;
            if (to || got_resp !== exp_resp || bad >= 0) begin
                n_errors++;
                $display("FAIL decode_write[%0d]: resp=%b expected %b to=%b mismatch_entry=%0d",
                         k, got_resp, exp_resp, to, bad);
            end
        end
    endtask

    task automatic test_flags_hold();
        logic [1:0]  wr_resp, exp_resp;
        logic [31:0] old_data;
        logic [1:0]  old_resp;
        bit          to;
        int          bad;
        exp_resp = model_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF);
        do_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, wr_resp, to);
        n_checks++;
        if (to || wr_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL flags_setup: resp=%b to=%b expected %b", wr_resp, to, exp_resp);
        end
        // Read and overwrite the same flags word in the same cycle
        model_read(BASE + 32'h1C, old_data, old_resp);
        exp_resp     = model_write(BASE + 32'h1C, 32'h0000_0001, 4'hF);
        req.r_ready  = 1'b0;
        req.b_ready  = 1'b1;
        req.ar_addr  = BASE + 32'h1C;
        req.aw_addr  = BASE + 32'h1C;
        req.w_data   = 32'h0000_0001;
        req.w_strb   = 4'hF;
        req.ar_valid = 1'b1;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        n_checks++;
        if (rsp.b_valid !== 1'b1 || rsp.b_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL flags_same_cycle_b: b_valid=%b b_resp=%b expected 1/%b", rsp.b_valid, rsp.b_resp, exp_resp);
        end
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (rsp.r_valid !== 1'b1 || rsp.r_data !== old_data || rsp.r_resp !== old_resp || rsp.ar_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL flags_hold[%0d]: r_valid=%b r_data=%h r_resp=%b ar_ready=%b expected 1/%h/%b/0",
                         c, rsp.r_valid, rsp.r_data, rsp.r_resp, rsp.ar_ready, old_data, old_resp);
            end
            @(negedge clk);
        end
        req.r_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp.r_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flags_r_release: r_valid=%b expected 0", rsp.r_valid);
        end
        bad = table_mismatch();
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL flags_table: entry %0d differs from model", bad);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, data, got_data, exp_data;
        logic [3:0]  strb;
        logic [1:0]  got_resp, exp_resp;
        bit          lat, to;
        int          bad, sel;
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      addr = BASE + 32'h1000 + ($urandom_range(0, 255) << 2);
            else if (sel == 1) addr = BASE - ($urandom_range(1, 16) << 2);
            else               addr = BASE + ($urandom_range(0, N + 1) << 4)
                                           + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 6) begin
                data     = $urandom;
                strb     = 4'($urandom_range(0, 15));
                exp_resp = model_write(addr, data, strb);
                do_write(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got_resp, to);
                bad = table_mismatch();
                n_checks++;
                if (to || got_resp !== exp_resp || bad >= 0) begin
                    n_errors++;
                    $display("FAIL random_write[%0d]: addr=%h strb=%b resp=%b expected %b to=%b mismatch_entry=%0d",
                             n, addr, strb, got_resp, exp_resp, to, bad);
                end
            end else begin
                model_read(addr, exp_data, exp_resp);
                do_read(addr, got_data, got_resp, lat, to);
                n_checks++;
                if (to || !lat || got_resp !== exp_resp || got_data !== exp_data) begin
                    n_errors++;
                    $display("FAIL random_read[%0d]: addr=%h data=%h resp=%b lat=%b expected %h/%b",
                             n, addr, got_data, got_resp, lat, exp_data, exp_resp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        req.r_ready  = 1'b1;
        req.ar_addr  = BASE + 32'h10;
        req.ar_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rsp.ar_ready !== ((k % 2) == 0)) begin
                n_errors++;
                $display("FAIL back_to_back_ar[%0d]: ar_ready=%b expected %0d", k, rsp.ar_ready, (k % 2) == 0);
            end
            @(negedge clk);
        end
        req.ar_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef TLB_CFG_LOCK_EN
    task automatic test_lock();
        logic [1:0]  got_resp, exp_resp;
        logic [31:0] got_data, exp_data;
        bit          lat, to;
        int          bad;
        exp_resp = model_write(BASE + 32'hFFC, 32'h1, 4'hF);
        do_write(BASE + 32'hFFC, 32'h1, 4'hF, 0, 0, got_resp, to);
        n_checks++;
        if (to || got_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL lock_set: resp=%b expected %b to=%b", got_resp, exp_resp, to);
        end
        exp_resp = model_write(BASE, 32'h5555_AAAA, 4'hF);
        do_write(BASE, 32'h5555_AAAA, 4'hF, 0, 0, got_resp, to);
        bad = table_mismatch();
        n_checks++;
        if (to || got_resp !== RespSlverr || got_resp !== exp_resp || bad >= 0) begin
            n_errors++;
            $display("FAIL lock_block: resp=%b expected %b mismatch_entry=%0d", got_resp, RespSlverr, bad);
        end
        model_read(BASE + 32'hFFC, exp_data, exp_resp);
        do_read(BASE + 32'hFFC, got_data, got_resp, lat, to);
        n_checks++;
        if (to || got_data !== 32'h1 || got_data !== exp_data || got_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL lock_read: data=%h resp=%b expected 00000001/%b", got_data, got_resp, exp_resp);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] got_data, exp_data;
        logic [1:0]  got_resp, exp_resp;
        bit          lat, to;
        model_lock   = 1'b0;
        req.aw_addr  = BASE + 32'h28;
        req.w_data   = 32'hDEAD_BEEF;
        req.w_strb   = 4'hF;
        req.b_ready  = 1'b0;
        req.aw_valid = 1'b1;
        req.w_valid  = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        n_checks++;
        if (rsp.b_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_pending: b_valid=%b expected 1", rsp.b_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp.b_valid !== 1'b0 || rsp.aw_ready !== 1'b1 || rsp.w_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_fsm: b_valid=%b aw_ready=%b w_ready=%b expected 0/1/1",
                     rsp.b_valid, rsp.aw_ready, rsp.w_ready);
        end
        n_checks++;
        if (entries !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_entries: table not cleared, expected all 0");
        end
        model_clear();
        @(negedge clk);
        rst_n       = 1'b1;
        req.b_ready = 1'b1;
        @(negedge clk);
        model_read(BASE + 32'h10, exp_data, exp_resp);
        do_read(BASE + 32'h10, got_data, got_resp, lat, to);
        n_checks++;
        if (to || got_data !== exp_data || got_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL reset_mid_readback: data=%h resp=%b expected %h/%b", got_data, got_resp, exp_data, exp_resp);
        end
        model_read(BASE + 32'hFFC, exp_data, exp_resp);
        do_read(BASE + 32'hFFC, got_data, got_resp, lat, to);
        n_checks++;
        if (to || got_data !== exp_data || got_resp !== exp_resp) begin
            n_errors++;
            $display("FAIL reset_mid_lock: data=%h resp=%b expected %h/%b", got_data, got_resp, exp_data, exp_resp);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_w_first();
        test_decode_errors();
        test_flags_hold();
        test_random();
        test_back_to_back();
`ifdef TLB_CFG_LOCK_EN
        test_lock();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_tlb_cfg_regs.md
# axi_lite_tlb_cfg_regs

AXI-Lite slave register file holding the C2H TLB entry table; it sits directly downstream of the host/cluster AXI-Lite crossbar on the C2H TLB configuration port (window 0x1040_0000–0x1040_0FFF). It accepts single-beat 32-bit reads and writes and exposes the decoded entry table as a flat output for the C2H TLB. Write and read channels run as independent handshake FSMs and return OKAY, SLVERR or DECERR responses.

## Interface
- NumEntries, 8, number of TLB entries; legal range 1..255
- AxiAddrWidth, 32, AXI-Lite address width
- AxiDataWidth, 32, AXI-Lite data width; only 32 is supported, elaboration fatal otherwise
- BaseAddr, 32'h1040_0000, base of the 4 KiB window
- req_lite_t, logic, AXI-Lite request struct type
- resp_lite_t, logic, AXI-Lite response struct type
- clk_i  input  1  single clock
- rst_ni  input  1  reset, asynchronous, active-low
- axi_req_i  input  req_lite_t  AXI-Lite request from crossbar
- axi_resp_o  output  resp_lite_t  AXI-Lite response to crossbar
- entries_o  output  NumEntries x tlb_entry_t  current entry table, registered

## Operation
- Offset = addr − BaseAddr; entry index = offset[11:4]; word = offset[3:2]; offset[1:0] is ignored.
- Each entry has four words:
  - word 0: first_page[31:0]
  - word 1: last_page[31:0]
  - word 2: base_page[31:0]
  - word 3: flags — bit0 valid, bit1 read_only, bits 31:2 read as 0 and writes to them are dropped.
- Index ≥ NumEntries, or address outside the window → DECERR. Writes to DECERR addresses have no effect; reads return 0.
- Byte strobes apply per byte. wstrb = 0 → OKAY with no update.
- Write FSM states W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
  - aw_ready is 1 in W_IDLE and W_WAIT_AW; w_ready is 1 in W_IDLE and W_WAIT_W.
  - AW alone → W_WAIT_W, with the address latched. W alone → W_WAIT_AW, with data and strobes latched.
  - Once both are captured, the register updates and the FSM enters W_RESP with b_valid=1. It returns to W_IDLE on b_ready.
- Read FSM states R_IDLE, R_RESP.
  - ar_ready=1 only in R_IDLE.
  - An AR handshake latches r_data/r_resp and enters R_RESP. It returns to R_IDLE on r_ready.
  - r_data and r_resp stay stable while r_valid=1 and r_ready=0.
- Entry registers reset to 0, i.e. all entries invalid.

## Timing
- Reset values: aw_ready=1, w_ready=1, ar_ready=1, b_valid=0, r_valid=0, b_resp=OKAY, r_resp=OKAY, r_data=0, entries_o all 0.
- Write: the register is updated at the clock edge ending the cycle in which the last of AW/W handshakes. b_valid rises the next cycle and entries_o reflects the new value in that same cycle.
- Read: AR handshake in cycle n → r_valid in cycle n+1.
- Throughput: at most one write per 2 cycles and one read per 2 cycles, assuming b_ready/r_ready are held at 1.
- Read and write to the same word completing in the same cycle: the read returns the pre-write value.
- No new AW/W is accepted while in W_RESP, and no new AR while in R_RESP.
- Reset asserted mid-transaction: the FSMs return to idle immediately, pending responses are dropped and all entries are cleared.

## Configuration
- TLB_CFG_LOCK_EN defined:
  - A lock register sits at offset 0xFFC; bit0 is sticky-set by a write of 1 and cleared only by reset. Reads return {31'b0, lock}.
  - While locked, writes to entry words return SLVERR with no update; reads are unaffected.
- TLB_CFG_LOCK_EN undefined: offset 0xFFC decodes as DECERR like any other unmapped offset, and writes are never blocked.

## Structure
- Package tlb_cfg_pkg holds:
  - tlb_entry_t (first_page, last_page, base_page, valid, read_only)
  - word offset constants (first/last/base/flags)
  - LockOffset = 12'hFFC
  - WindowSize = 32'h1000
- No sub-module. Decode, the two FSMs and the register array live in one module.

## Test plan
- Write 0x0000_1234 to 0x1040_0010 (entry 1, word 0) with AW and W in the same cycle → b_valid one cycle later with OKAY; entries_o[1].first_page = 0x1234.
- W presented 3 cycles before AW, wstrb=4'b0010, data 0xAABB_CCDD, over an existing value 0 → final value 0x0000_CC00; exactly one B response.
- Read 0x1040_0090 with NumEntries=8 (index 9) → r_resp=DECERR, r_data=0; write to the same address → DECERR and entries_o unchanged.
- Hold r_ready=0 for 4 cycles after reading flags word 0x1040_001C → r_valid held and r_data stable at {30'b0, read_only, valid}. Same-cycle write to that word → the read returns the old value.
- With TLB_CFG_LOCK_EN: write 1 to 0x1040_0FFC, then write entry 0 → SLVERR and no change; a read of 0xFFC returns 1. After reset, the lock reads 0.
- Assert rst_ni low while b_valid=1 → b_valid=0, aw_ready=1 and entries_o all zero in the same cycle.
